// File: rtl/uart_pkg.sv
// Shared state encoding and timing constants for the UART receive sequencer.
package uart_pkg;

   localparam int OVS           = 16;
   localparam int MID_TICK      = 7;
   localparam int LAST_TICK     = OVS - 1;
   localparam int DATA_BITS_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line; resets to the idle level.
module rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_seq.sv
// Receive-frame sequencer: start qualification, mid-bit data sampling, stop check
// and a single-entry holding register with full/overrun/framing status.
module uart_rx_seq
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = DATA_BITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           fr_div,
   input  logic                 rxd,
   input  logic                 rd,
   output logic [DATA_BITS-1:0] dout,
   output logic                 vld_rx,
   output logic                 rx_full,
   output logic                 frm_err,
   output logic                 ovr_err,
   output logic                 busy
);

   localparam logic [3:0] MID     = 4'(MID_TICK);
   localparam logic [3:0] LAST    = 4'(LAST_TICK);
   localparam logic [2:0] TOP_BIT = 3'(DATA_BITS - 1);

   rx_state_t            state, state_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic [2:0]           bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] sr, sr_nxt;
   logic                 rxd_s;
   logic                 tick;
   logic                 stop_mid;
   logic                 load_good;
   logic                 load_ovr;
   logic                 stop_bad;

   rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

   assign tick = (fr_div == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sr      <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         sr      <= sr_nxt;
      end
   end

   // The 4-bit counter wraps 15 -> 0 on its own, which doubles as the reset at each sample point.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      sr_nxt      = sr;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state_nxt = START;
                  cnt_nxt   = 4'd1;
               end
            end
            START: begin
               if (rxd_s) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt == MID) begin
                  state_nxt   = DATA;
                  cnt_nxt     = '0;
                  bit_idx_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
            DATA: begin
               cnt_nxt = cnt + 4'd1;
               if (cnt == LAST) begin
                  sr_nxt = {rxd_s, sr[DATA_BITS-1:1]};
                  if (bit_idx == TOP_BIT) begin
                     state_nxt = STOP;
                  end else begin
                     bit_idx_nxt = bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               cnt_nxt = cnt + 4'd1;
               if (cnt == LAST) begin
                  state_nxt = rxd_s ? IDLE : BRK;
               end
            end
            BRK: begin
               if (rxd_s) begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stop_mid  = tick && (state == STOP) && (cnt == LAST);
      load_good = stop_mid && rxd_s && !rx_full;
      load_ovr  = stop_mid && rxd_s && rx_full;
      stop_bad  = stop_mid && !rxd_s;
      busy      = (state != IDLE);
   end

   // A load on the same edge as rd wins, so the consumer never loses a freshly arrived byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout    <= '0;
         vld_rx  <= 1'b0;
         rx_full <= 1'b0;
         frm_err <= 1'b0;
         ovr_err <= 1'b0;
      end else begin
         vld_rx  <= load_good;
         frm_err <= stop_bad;
         if (load_good) begin
            dout    <= sr;
            rx_full <= 1'b1;
         end else if (rd) begin
            rx_full <= 1'b0;
         end
         if (load_ovr) begin
            ovr_err <= 1'b1;
         end else if (rd) begin
            ovr_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_seq.sv
// Bench for uart_rx_seq: frame-level event schedule checked every cycle, plus literal spot checks.
module tb_uart_rx_seq;

   localparam int DW       = 8;
   localparam int BIT_CLKS = 256;
   // Edges from an aligned line change to the mid-stop decision: 9 to the first tick, then 151 ticks.
   localparam int STOP_OFFSET = 9 + (7 + 16 * (DW + 1)) * 16;

   logic          clk;
   logic          rst;
   logic [3:0]    fr_div;
   logic          rxd;
   logic          rd;
   logic [DW-1:0] dout;
   logic          vld_rx;
   logic          rx_full;
   logic          frm_err;
   logic          ovr_err;
   logic          busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int vld_seen     = 0;
   int frm_seen     = 0;
   bit cmp_en       = 1'b0;

   logic [DW-1:0] good_ev[int];
   bit            bad_ev[int];
   bit            rd_ev[int];
   bit            rst_ev[int];
   bit            start_ev[int];
   bit            idle_ev[int];

   logic [DW-1:0] m_dout = '0;
   logic          m_full = 1'b0;
   logic          m_ovr  = 1'b0;
   logic          m_busy = 1'b0;

   uart_rx_seq #(.DATA_BITS(DW), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .fr_div  (fr_div),
      .rxd     (rxd),
      .rd      (rd),
      .dout    (dout),
      .vld_rx  (vld_rx),
      .rx_full (rx_full),
      .frm_err (frm_err),
      .ovr_err (ovr_err),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      fr_div = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         fr_div = fr_div + 4'd1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got time limit reached, expected run to complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Model step for edge n: apply whatever the schedule says happened, then compare all outputs.
   task automatic modelStep(input int n);
      logic          exp_vld;
      logic          exp_frm;
      logic          load;
      logic          ovr_set;
      logic [DW+4:0] exp_vec;
      logic [DW+4:0] act_vec;
      exp_vld = 1'b0;
      exp_frm = 1'b0;
      load    = 1'b0;
      ovr_set = 1'b0;
      if (rst_ev.exists(n)) begin
         m_dout = '0;
         m_full = 1'b0;
         m_ovr  = 1'b0;
         m_busy = 1'b0;
      end else begin
         if (good_ev.exists(n)) begin
            if (!m_full) begin
               m_dout  = good_ev[n];
               exp_vld = 1'b1;
               load    = 1'b1;
            end else begin
               ovr_set = 1'b1;
            end
         end
         if (bad_ev.exists(n)) exp_frm = 1'b1;
         if (rd_ev.exists(n)) begin
            if (!load) m_full = 1'b0;
            m_ovr = 1'b0;
         end
         if (load) m_full = 1'b1;
         if (ovr_set) m_ovr = 1'b1;
         if (start_ev.exists(n)) m_busy = 1'b1;
         if (idle_ev.exists(n)) m_busy = 1'b0;
      end
      exp_vec = {m_dout, exp_vld, m_full, exp_frm, m_ovr, m_busy};
      act_vec = {dout, vld_rx, rx_full, frm_err, ovr_err, busy};
      tests_run++;
      if (act_vec !== exp_vec) begin
         tests_failed++;
         $display("[TB] FAIL cycle %0d outputs: got dout=%h vld=%b full=%b frm=%b ovr=%b busy=%b, expected dout=%h vld=%b full=%b frm=%b ovr=%b busy=%b",
                  n, dout, vld_rx, rx_full, frm_err, ovr_err, busy,
                  m_dout, exp_vld, m_full, exp_frm, m_ovr, m_busy);
      end
      if (vld_rx) vld_seen++;
      if (frm_err) frm_seen++;
   endtask

   always @(negedge clk) begin
      if (cmp_en) modelStep(cyc);
   end

   task automatic waitClks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Line changes happen midway between ticks so each is seen by the tick 9 edges later.
   task automatic alignBit();
      @(negedge clk);
      while (fr_div != 4'd8) @(negedge clk);
   endtask

   task automatic pulseRd();
      @(negedge clk);
      rd = 1'b1;
      rd_ev[cyc + 1] = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic releaseLine();
      alignBit();
      rxd = 1'b1;
      idle_ev[cyc + 9] = 1'b1;
   endtask

   task automatic applyStimulus(input logic [DW-1:0] data, input logic stop_bit, input bit rd_on_load);
      logic [DW+1:0] frame;
      int            dec;
      frame = {stop_bit, data, 1'b0};
      alignBit();
      dec = cyc + STOP_OFFSET;
      start_ev[cyc + 9] = 1'b1;
      if (stop_bit) begin
         good_ev[dec] = data;
         idle_ev[dec] = 1'b1;
         if (rd_on_load) rd_ev[dec] = 1'b1;
      end else begin
         bad_ev[dec] = 1'b1;
      end
      for (int b = 0; b < DW + 2; b++) begin
         rxd = frame[b];
         for (int k = 0; k < BIT_CLKS; k++) begin
            rd = rd_on_load && (cyc == dec - 1);
            @(negedge clk);
         end
      end
      rd = 1'b0;
   endtask

   initial begin
      int v0;
      int f0;
      logic [DW+1:0] part;
      rst = 1'b1;
      rxd = 1'b1;
      rd  = 1'b0;
      waitClks(4);
      rst = 1'b0;
      cmp_en = 1'b1;
      waitClks(2);

      checkOutput("reset dout", int'(dout), 0);
      checkOutput("reset vld_rx", int'(vld_rx), 0);
      checkOutput("reset rx_full", int'(rx_full), 0);
      checkOutput("reset frm_err", int'(frm_err), 0);
      checkOutput("reset ovr_err", int'(ovr_err), 0);
      checkOutput("reset busy", int'(busy), 0);

      v0 = vld_seen;
      f0 = frm_seen;
      applyStimulus(8'hA5, 1'b1, 1'b0);
      checkOutput("A5 dout", int'(dout), 'hA5);
      checkOutput("A5 rx_full", int'(rx_full), 1);
      checkOutput("A5 vld_rx pulse count", vld_seen - v0, 1);
      checkOutput("A5 frm_err count", frm_seen - f0, 0);
      checkOutput("A5 busy after frame", int'(busy), 0);
      pulseRd();

      v0 = vld_seen;
      alignBit();
      start_ev[cyc + 9] = 1'b1;
      idle_ev[cyc + 89] = 1'b1;
      rxd = 1'b0;
      waitClks(80);
      rxd = 1'b1;
      waitClks(200);
      checkOutput("glitch vld_rx count", vld_seen - v0, 0);
      checkOutput("glitch busy", int'(busy), 0);
      applyStimulus(8'h3C, 1'b1, 1'b0);
      checkOutput("3C dout", int'(dout), 'h3C);
      pulseRd();

      f0 = frm_seen;
      v0 = vld_seen;
      applyStimulus(8'h00, 1'b0, 1'b0);
      waitClks(40 * 16);
      checkOutput("break frm_err count", frm_seen - f0, 1);
      checkOutput("break dout kept", int'(dout), 'h3C);
      checkOutput("break busy held", int'(busy), 1);
      checkOutput("break vld_rx count", vld_seen - v0, 0);
      releaseLine();
      waitClks(64);
      checkOutput("break exit busy", int'(busy), 0);
      applyStimulus(8'h7E, 1'b1, 1'b0);
      checkOutput("7E dout", int'(dout), 'h7E);
      pulseRd();

      v0 = vld_seen;
      applyStimulus(8'h11, 1'b1, 1'b0);
      applyStimulus(8'h22, 1'b1, 1'b0);
      checkOutput("overrun dout", int'(dout), 'h11);
      checkOutput("overrun ovr_err", int'(ovr_err), 1);
      checkOutput("overrun vld_rx count", vld_seen - v0, 1);
      pulseRd();
      @(negedge clk);
      checkOutput("rd clears rx_full", int'(rx_full), 0);
      checkOutput("rd clears ovr_err", int'(ovr_err), 0);

      v0 = vld_seen;
      applyStimulus(8'h55, 1'b1, 1'b1);
      checkOutput("rd+load dout", int'(dout), 'h55);
      checkOutput("rd+load rx_full", int'(rx_full), 1);
      checkOutput("rd+load vld_rx count", vld_seen - v0, 1);

      // Frame 0x96 cut off by reset halfway through data bit 4.
      v0 = vld_seen;
      part = {1'b1, 8'h96, 1'b0};
      alignBit();
      start_ev[cyc + 9] = 1'b1;
      for (int b = 0; b < 6; b++) begin
         rxd = part[b];
         waitClks(b == 5 ? BIT_CLKS / 2 : BIT_CLKS);
      end
      rst = 1'b1;
      rxd = 1'b1;
      rst_ev[cyc + 1] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid-frame reset dout", int'(dout), 0);
      checkOutput("mid-frame reset rx_full", int'(rx_full), 0);
      checkOutput("mid-frame reset busy", int'(busy), 0);
      checkOutput("mid-frame reset vld_rx", int'(vld_rx), 0);
      waitClks(BIT_CLKS * 6);
      checkOutput("post-reset vld_rx count", vld_seen - v0, 0);
      checkOutput("post-reset busy", int'(busy), 0);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_seq.md
Name: uart_rx_seq

Overview:
Receive-frame sequencer for the serial debug unit's UART input. It runs on the 16x oversample tick from the baud divider and does four jobs:
- qualifies the start bit at mid-bit;
- samples the data bits at mid-bit centres;
- checks the stop bit;
- hands each completed byte to the command decoder through a holding register with full/read handshake and error flags.
It replaces ad-hoc start detection with one FSM that owns the whole receive timeline.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first, range 5..8
OVS, 16, oversample ticks per bit period; fixed at 16 because fr_div is 4 bits
SYNC_STAGES, 2, flip-flop stages on rxd before use

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
fr_div  in  4  free-running divider count; tick = (fr_div == 0), one clk wide
rxd  in  1  asynchronous serial line, idle high
rd  in  1  consumer pulse; clears rx_full and ovr_err
dout  out  DATA_BITS  last accepted byte
vld_rx  out  1  one-cycle pulse when a byte is loaded into dout
rx_full  out  1  holding register occupied
frm_err  out  1  one-cycle pulse when stop bit is sampled low
ovr_err  out  1  sticky: a good byte arrived while rx_full = 1
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (sync, rst = 1 at clk edge) values: dout = 0, vld_rx = 0, rx_full = 0, frm_err = 0, ovr_err = 0, busy = 0, state = IDLE, cnt = 0, bit_idx = 0, all sync flops = 1. Reset mid-frame abandons the frame with no flags.
- rxd passes through SYNC_STAGES flops to give rxd_s. All decisions use rxd_s and advance only on tick cycles. Non-tick cycles hold state, except the rd handling and the output pulse clearing.
- cnt is 4 bits and wraps 15 -> 0. bit_idx is 3 bits.
- IDLE: on tick with rxd_s = 0 -> START, cnt = 1.
- START: on tick with rxd_s = 1 -> IDLE (glitch, no flag). Otherwise cnt++. On the tick where cnt == 7 (8th consecutive low sample) -> DATA, cnt = 0, bit_idx = 0.
- DATA: each tick cnt++. On the tick where cnt == 15, sample rxd_s into shift register sr (shift right, new bit into MSB of a DATA_BITS-wide register) and set cnt = 0. If bit_idx == DATA_BITS-1 -> STOP, else bit_idx++.
- STOP: each tick cnt++. On the tick where cnt == 15, sample rxd_s.
  - Sample = 1: if rx_full = 0, load dout = sr, set rx_full, pulse vld_rx; if rx_full = 1, keep dout and set ovr_err. Go to IDLE.
  - Sample = 0: pulse frm_err, drop the byte, go to BRK.
- BRK: wait for a tick with rxd_s = 1 -> IDLE. This stops a break condition from retriggering reception.
- Output timing: vld_rx and frm_err are registered. They are high exactly the one clk after the deciding edge. Latency from the stop-bit mid-sample tick to vld_rx is 1 clk.
- rd = 1 clears rx_full and ovr_err on the next edge. If rd and a load occur on the same edge, the load wins: rx_full = 1, vld_rx pulses, ovr_err is cleared.
- busy = (state != IDLE).
- Every tick-qualified transition happens only when fr_div == 0. If fr_div stalls at a nonzero value, the FSM freezes.

Decomposition:
- Package uart_pkg holds:
  - state encoding (IDLE, START, DATA, STOP, BRK; 3 bits);
  - constants OVS = 16, MID_TICK = 7, LAST_TICK = 15;
  - DATA_BITS default.
- Sub-module rx_sync holds the parameterised SYNC_STAGES double-flop, reset value 1. The FSM, counters, shift register and holding register stay in uart_rx_seq.

Test Plan:
- Frame 0xA5 at 16 ticks/bit (fr_div counting 0..15 every clk), stop = 1 -> dout = 0xA5, vld_rx high exactly 1 clk, rx_full = 1, frm_err = 0, busy back to 0.
- Start glitch: rxd low for 5 ticks then high -> returns to IDLE, no vld_rx, no frm_err. A following valid 0x3C is received correctly.
- Frame 0x00 with stop bit low, line held low a further 40 ticks -> frm_err pulses once, dout unchanged, FSM stays in BRK until rxd is high. A following 0x7E is received.
- Two good frames 0x11 then 0x22 without rd -> dout = 0x11, ovr_err = 1, second vld_rx absent. Then rd -> rx_full = 0, ovr_err = 0.
- rd asserted on the same clk that 0x55 loads -> rx_full = 1, dout = 0x55, vld_rx pulses.
- rst asserted at bit 4 of a frame -> all outputs 0 next clk, busy = 0. The remainder of the frame (line high) produces no vld_rx.
